// File: rtl/dmi_halt_injector_if.sv
// DMI request/response link: request {addr[6:0], op[1:0], data[31:0]}, response {data[31:0], resp[1:0]}.
// A transfer on either channel completes in a cycle where valid and ready are both high; the request
// payload stays stable from valid rising until that cycle, and valid never drops before it.
interface dmi_halt_injector_if;
    logic [40:0] req;
    logic        req_valid;
    logic        req_ready;
    logic [33:0] resp;
    logic        resp_valid;
    logic        resp_ready;

    modport master (
        output req, req_valid, resp_ready,
        input  req_ready, resp, resp_valid
    );

    modport slave (
        input  req, req_valid, resp_ready,
        output req_ready, resp, resp_valid
    );
endinterface

// File: rtl/dmi_halt_injector.sv
// Sits between the DTM and dm_csrs, passing host DMI traffic through and arbitrating in local
// dmcontrol writes: dmactive after reset, haltreq/resumereq following a filtered halt pin.
module dmi_halt_injector #(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned FilterCycles  = 4,
    parameter logic [6:0]  DmcontrolAddr = 7'h10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        halt_req_pin_i,
    input  logic                        dmi_rst_ni,
    dmi_halt_injector_if.slave          host,
    dmi_halt_injector_if.master         dm,
    output logic                        dmi_rst_no,
    output logic                        halt_active_o,
    output logic                        inj_busy_o,
    output logic                        inj_err_o,
    output logic [2:0]                  state_o
);

    localparam int unsigned CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);
    localparam logic [31:0] InitData   = 32'h0000_0001;
    localparam logic [31:0] HaltData   = 32'h8000_0001;
    localparam logic [31:0] ResumeData = 32'h4000_0001;
    localparam logic [1:0]  OpWrite    = 2'h2;

    typedef enum logic [2:0] {
        INIT_REQ = 3'd0,
        INIT_RSP = 3'd1,
        IDLE     = 3'd2,
        HOST_RSP = 3'd3,
        INJ_REQ  = 3'd4,
        INJ_RSP  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  filt_q, filt_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  sent_q, sent_d;
    logic                  lvl_q, lvl_d;
    logic                  err_q, err_d;
    logic                  synced;
    logic                  inject_now;

    assign synced     = sync_q[SyncStages-1];
    assign inject_now = (filt_q != sent_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= INIT_REQ;
            sync_q  <= '0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
            sent_q  <= 1'b0;
            lvl_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            lvl_q   <= lvl_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], halt_req_pin_i};
        filt_d  = filt_q;
        cnt_d   = '0;
        state_d = state_q;
        sent_d  = sent_q;
        lvl_d   = lvl_q;
        err_d   = err_q;

        // The filtered level only flips after FilterCycles consecutive cycles of disagreement.
        if (synced != filt_q) begin
            if (cnt_q == CntMax) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        unique case (state_q)
            INIT_REQ: if (dm.req_ready) state_d = INIT_RSP;
            INIT_RSP: begin
                if (dm.resp_valid) begin
                    state_d = IDLE;
                    if (dm.resp[1:0] != 2'b00) err_d = 1'b1;
                end
            end
            IDLE: begin
                if (inject_now) begin
                    state_d = INJ_REQ;
                    lvl_d   = filt_q;
                end else if (host.req_valid && dm.req_ready) begin
                    state_d = HOST_RSP;
                end
            end
            HOST_RSP: if (dm.resp_valid && host.resp_ready) state_d = IDLE;
            INJ_REQ:  if (dm.req_ready) state_d = INJ_RSP;
            INJ_RSP: begin
                if (dm.resp_valid) begin
                    state_d = IDLE;
                    sent_d  = lvl_q;
                    if (dm.resp[1:0] != 2'b00) err_d = 1'b1;
                end
            end
            default: state_d = INIT_REQ;
        endcase
    end

    always_comb begin
        dm.req          = '0;
        dm.req_valid    = 1'b0;
        dm.resp_ready   = 1'b0;
        host.req_ready  = 1'b0;
        host.resp       = '0;
        host.resp_valid = 1'b0;

        unique case (state_q)
            INIT_REQ: begin
                dm.req       = {DmcontrolAddr, OpWrite, InitData};
                dm.req_valid = 1'b1;
            end
            INIT_RSP: dm.resp_ready = 1'b1;
            IDLE: begin
                if (!inject_now) begin
                    dm.req         = host.req;
                    dm.req_valid   = host.req_valid;
                    host.req_ready = dm.req_ready;
                end
            end
            HOST_RSP: begin
                host.resp       = dm.resp;
                host.resp_valid = dm.resp_valid;
                dm.resp_ready   = host.resp_ready;
            end
            INJ_REQ: begin
                dm.req       = {DmcontrolAddr, OpWrite, lvl_q ? HaltData : ResumeData};
                dm.req_valid = 1'b1;
            end
            INJ_RSP: dm.resp_ready = 1'b1;
            default: ;
        endcase

        // Handshakes are held off while reset is asserted so nothing leaks before the FSM restarts.
        if (!rst_ni) begin
            dm.req_valid    = 1'b0;
            dm.resp_ready   = 1'b0;
            host.req_ready  = 1'b0;
            host.resp_valid = 1'b0;
        end
    end

    assign dmi_rst_no    = dmi_rst_ni;
    assign halt_active_o = sent_q;
    assign inj_err_o     = err_q;
    assign inj_busy_o    = (state_q == INIT_REQ) || (state_q == INIT_RSP) ||
                           (state_q == INJ_REQ)  || (state_q == INJ_RSP);
    assign state_o       = state_q;

endmodule

// File: tb/tb_dmi_halt_injector.sv
// Directed bench for dmi_halt_injector: DM responder model, host driver, and a scoreboard monitor
// that pops expected DM-side requests and host responses as they are handshaked.
module tb_dmi_halt_injector;
    logic       clk;
    logic       rst_ni;
    logic       halt_pin;
    logic       dmi_rst_ni;
    logic       dmi_rst_no;
    logic       halt_active;
    logic       inj_busy;
    logic       inj_err;
    logic [2:0] state;

    dmi_halt_injector_if host_bus ();
    dmi_halt_injector_if dm_bus ();

    dmi_halt_injector dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .halt_req_pin_i (halt_pin),
        .dmi_rst_ni     (dmi_rst_ni),
        .host           (host_bus),
        .dm             (dm_bus),
        .dmi_rst_no     (dmi_rst_no),
        .halt_active_o  (halt_active),
        .inj_busy_o     (inj_busy),
        .inj_err_o      (inj_err),
        .state_o        (state)
    );

    localparam logic [40:0] WR_INIT   = {7'h10, 2'h2, 32'h0000_0001};
    localparam logic [40:0] WR_HALT   = {7'h10, 2'h2, 32'h8000_0001};
    localparam logic [40:0] WR_RESUME = {7'h10, 2'h2, 32'h4000_0001};

    logic [40:0] exp_q[$];
    logic [33:0] exp_rsp_q[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] rsp_data;
    logic [1:0]  rsp_code;
    int          rsp_delay;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- DM responder model ----------------
    initial begin
        logic req_hs, rsp_hs, pend;
        int cd;
        pend = 1'b0;
        cd = 0;
        dm_bus.req_ready  = 1'b1;
        dm_bus.resp_valid = 1'b0;
        dm_bus.resp       = '0;
        forever begin
            @(negedge clk);
            req_hs = dm_bus.req_valid && dm_bus.req_ready;
            rsp_hs = dm_bus.resp_valid && dm_bus.resp_ready;
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                dm_bus.resp_valid = 1'b0;
                pend = 1'b0;
            end else begin
                if (rsp_hs) dm_bus.resp_valid = 1'b0;
                if (req_hs) begin
                    pend = 1'b1;
                    cd = rsp_delay;
                end
                if (pend) begin
                    if (cd == 0) begin
                        dm_bus.resp_valid = 1'b1;
                        dm_bus.resp = {rsp_data, rsp_code};
                        pend = 1'b0;
                    end else begin
                        cd--;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_ni) begin
            if (dm_bus.req_valid && dm_bus.req_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dm_req_extra: got %0h expected none", dm_bus.req);
                end else begin
                    check("dm_req", {23'd0, dm_bus.req}, {23'd0, exp_q.pop_front()});
                end
            end
            if (host_bus.resp_valid && host_bus.resp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL host_rsp_extra: got %0h expected none", host_bus.resp);
                end else begin
                    check("host_rsp", {30'd0, host_bus.resp}, {30'd0, exp_rsp_q.pop_front()});
                end
            end
            if (inj_busy) begin
                check("host_req_ready_blocked", {63'd0, host_bus.req_ready}, 64'd0);
                check("host_resp_valid_blocked", {63'd0, host_bus.resp_valid}, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bit hit;

        rst_ni              = 1'b0;
        halt_pin            = 1'b0;
        dmi_rst_ni          = 1'b1;
        host_bus.req        = '0;
        host_bus.req_valid  = 1'b0;
        host_bus.resp_ready = 1'b1;
        rsp_data            = 32'h0;
        rsp_code            = 2'b00;
        rsp_delay           = 0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dm_req_valid", {63'd0, dm_bus.req_valid}, 64'd0);
        check("rst_dm_resp_ready", {63'd0, dm_bus.resp_ready}, 64'd0);
        check("rst_host_req_ready", {63'd0, host_bus.req_ready}, 64'd0);
        check("rst_host_resp_valid", {63'd0, host_bus.resp_valid}, 64'd0);
        check("rst_halt_active", {63'd0, halt_active}, 64'd0);
        check("rst_inj_err", {63'd0, inj_err}, 64'd0);
        dmi_rst_ni = 1'b0;
        #1 check("dmi_rst_low", {63'd0, dmi_rst_no}, 64'd0);
        dmi_rst_ni = 1'b1;
        #1 check("dmi_rst_high", {63'd0, dmi_rst_no}, 64'd1);

        // 1: INIT write after reset release
        exp_q.push_back(WR_INIT);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_busy_low", {63'd0, inj_busy}, 64'd0);
        check("t1_init_seen", 64'(exp_q.size()), 64'd0);

        // 2: pin rise -> HALT after 7 cycles, release -> RESUME
        exp_q.push_back(WR_HALT);
        @(posedge clk);
        #1 halt_pin = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dm_bus.req_valid) begin
                lat = k;
                break;
            end
        end
        check("t2_halt_latency", 64'(lat), 64'd7);
        cycles(10);
        check("t2_halt_active", {63'd0, halt_active}, 64'd1);
        exp_q.push_back(WR_RESUME);
        halt_pin = 1'b0;
        cycles(15);
        check("t2_resume_active", {63'd0, halt_active}, 64'd0);

        // 3: short glitch is ignored
        halt_pin = 1'b1;
        cycles(3);
        halt_pin = 1'b0;
        cycles(12);
        check("t3_no_halt", {63'd0, halt_active}, 64'd0);
        check("t3_cnt_zero", 64'(dut.cnt_q), 64'd0);

        // 4: host read in flight while pin rises
        rsp_data = 32'hCAFE_0011;
        host_bus.resp_ready = 1'b0;
        exp_q.push_back({7'h11, 2'h1, 32'h0});
        exp_q.push_back(WR_HALT);
        exp_rsp_q.push_back({32'hCAFE_0011, 2'b00});
        halt_pin = 1'b1;
        host_bus.req = {7'h11, 2'h1, 32'h0};
        host_bus.req_valid = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (host_bus.req_ready) begin
                hit = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 host_bus.req_valid = 1'b0;
        check("t4_host_accepted", {63'd0, hit}, 64'd1);
        cycles(12);
        check("t4_halt_waits", {63'd0, halt_active}, 64'd0);
        check("t4_rsp_pending", 64'(exp_rsp_q.size()), 64'd1);
        host_bus.resp_ready = 1'b1;
        cycles(10);
        check("t4_halt_after", {63'd0, halt_active}, 64'd1);
        check("t4_rsp_done", 64'(exp_rsp_q.size()), 64'd0);
        exp_q.push_back(WR_RESUME);
        halt_pin = 1'b0;
        cycles(15);
        check("t4_resumed", {63'd0, halt_active}, 64'd0);

        // 5: toggles during slow injections, HALT answered with error
        rsp_code = 2'b10;
        rsp_delay = 30;
        exp_q.push_back(WR_HALT);
        exp_q.push_back(WR_RESUME);
        halt_pin = 1'b1;
        cycles(12);
        halt_pin = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (halt_active) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_halt_done", {63'd0, hit}, 64'd1);
        check("t5_err_set", {63'd0, inj_err}, 64'd1);
        cycles(3);
        halt_pin = 1'b1;
        cycles(10);
        halt_pin = 1'b0;
        cycles(60);
        check("t5_resumed", {63'd0, halt_active}, 64'd0);
        check("t5_err_sticky", {63'd0, inj_err}, 64'd1);
        check("t5_no_extra", 64'(exp_q.size()), 64'd0);

        // 6: reset during INJ_RSP
        rsp_code = 2'b00;
        exp_q.push_back(WR_HALT);
        halt_pin = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (inj_busy && dm_bus.resp_ready) begin
                hit = 1'b1;
                break;
            end
        end
        check("t6_in_inj_rsp", {63'd0, hit}, 64'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        halt_pin = 1'b0;
        rsp_delay = 0;
        @(negedge clk);
        check("t6_dm_valid", {63'd0, dm_bus.req_valid}, 64'd0);
        check("t6_dm_ready", {63'd0, dm_bus.resp_ready}, 64'd0);
        check("t6_host_ready", {63'd0, host_bus.req_ready}, 64'd0);
        check("t6_host_valid", {63'd0, host_bus.resp_valid}, 64'd0);
        @(negedge clk);
        check("t6_dm_valid_hold", {63'd0, dm_bus.req_valid}, 64'd0);
        check("t6_halt_cleared", {63'd0, halt_active}, 64'd0);
        exp_q.push_back(WR_INIT);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        cycles(10);
        check("t6_halt_active", {63'd0, halt_active}, 64'd0);
        check("t6_err_cleared", {63'd0, inj_err}, 64'd0);
        check("t6_busy_low", {63'd0, inj_busy}, 64'd0);

        @(negedge clk);
        check("final_req_queue", 64'(exp_q.size()), 64'd0);
        check("final_rsp_queue", 64'(exp_rsp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmi_halt_injector.md
Name: dmi_halt_injector

Overview:
- Sits on the DMI link between the JTAG DTM (dmi_jtag) and the DM CSR block (dm_csrs).
- Passes host DMI traffic through unchanged.
- Arbitrates in locally generated dmcontrol writes: dmactive at start-up, haltreq when the halt pin is asserted, resumereq when it is released.
- Responses to injected writes are consumed locally and never reach the host.

Parameters:
SyncStages, 2, flops in halt pin synchroniser (>=2)
FilterCycles, 4, consecutive cycles the synchronised pin must differ from the filtered level before that level flips (>=1)
DmcontrolAddr, 7'h10, DMI address of dmcontrol

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
halt_req_pin_i  in  1  asynchronous external halt request, level
dmi_rst_ni  in  1  DMI reset from DTM
dmi_req_i  in  dm::dmi_req_t  host request {addr[6:0], op[1:0], data[31:0]}
dmi_req_valid_i  in  1  host request valid
dmi_req_ready_o  out  1  host request ready
dmi_resp_o  out  dm::dmi_resp_t  host response {data[31:0], resp[1:0]}
dmi_resp_valid_o  out  1  host response valid
dmi_resp_ready_i  in  1  host response ready
dmi_rst_no  out  1  DMI reset to DM, equals dmi_rst_ni
dmi_req_o  out  dm::dmi_req_t  request to DM
dmi_req_valid_o  out  1  request valid to DM
dmi_req_ready_i  in  1  DM request ready
dmi_resp_i  in  dm::dmi_resp_t  DM response
dmi_resp_valid_i  in  1  DM response valid
dmi_resp_ready_o  out  1  response ready to DM
halt_active_o  out  1  level last successfully injected (1 = haltreq sent)
inj_busy_o  out  1  injection transaction in flight (INIT_*/INJ_* states)
inj_err_o  out  1  sticky: an injected write returned resp != 0

Behaviour:
- Reset (rst_ni low at posedge):
  - State INIT_REQ; synchroniser, filtered level, filter counter, sent level and inj_err_o all 0.
  - While rst_ni is low, dmi_req_valid_o, dmi_resp_ready_o, dmi_req_ready_o and dmi_resp_valid_o are forced to 0.
  - Reset mid-transaction abandons it; the DM side is reset by the same rst_ni.
- Filter:
  - Counter increments each cycle the synchronised pin differs from the filtered level; it clears whenever they are equal.
  - At count FilterCycles-1 with the difference still present, the filtered level flips and the counter clears.
  - Pin edge to dmi_req_valid_o in IDLE = SyncStages+FilterCycles+1 cycles.
  - Glitches shorter than FilterCycles synchronised cycles are ignored.
- Injected payloads, all with op=2'h2 (write) and addr=DmcontrolAddr:
  - INIT: data 32'h0000_0001
  - HALT: 32'h8000_0001
  - RESUME: 32'h4000_0001
- FSM states: INIT_REQ, INIT_RSP, IDLE, HOST_RSP, INJ_REQ, INJ_RSP.
  - INIT_REQ: valid_o=1, payload INIT; on dmi_req_ready_i go to INIT_RSP.
  - INIT_RSP: resp_ready_o=1; on dmi_resp_valid_i go to IDLE. resp!=0 sets inj_err_o.
  - IDLE:
    - If filtered != sent, go to INJ_REQ. This has priority: dmi_req_ready_o=0 that cycle and the host is not forwarded.
    - Else host passthrough (combinational): dmi_req_o=dmi_req_i, dmi_req_valid_o=dmi_req_valid_i, dmi_req_ready_o=dmi_req_ready_i.
    - A host handshake goes to HOST_RSP.
  - HOST_RSP: dmi_resp_o=dmi_resp_i, dmi_resp_valid_o=dmi_resp_valid_i, dmi_resp_ready_o=dmi_resp_ready_i; on response handshake go to IDLE. Injection waits; the host is never interrupted.
  - INJ_REQ:
    - Payload is registered on entry: HALT if filtered=1, else RESUME. It is held stable while valid until ready.
    - dmi_req_ready_o=0. On ready, record the payload level as pending and go to INJ_RSP.
  - INJ_RSP:
    - resp_ready_o=1, dmi_resp_valid_o=0 (response swallowed).
    - On valid: sent level := pending level, halt_active_o updates; resp!=0 sets inj_err_o; go to IDLE.
- Coalescing: if the pin toggles while an injection is in flight, IDLE re-evaluates filtered vs sent afterwards. A net-zero toggle produces no further write.
- Outside the passthrough states: dmi_req_ready_o=0, dmi_resp_valid_o=0, dmi_resp_o='0.
- dmi_rst_no = dmi_rst_ni combinationally at all times.

Test Plan:
1. Release reset, DM ready=1, response after 1 cycle -> one write {10,2,0000_0001} in INIT_REQ; no host response; IDLE by cycle 3; inj_busy_o low afterwards.
2. Pin 0->1 in IDLE, held -> dmi_req_valid_o high 7 cycles later with data 8000_0001; halt_active_o=1 after response. Release -> data 4000_0001; halt_active_o=0.
3. 3-cycle pin pulse -> no injection; filter counter returns to 0.
4. Host read of addr 7'h11 in flight while pin rises -> host response delivered first, then HALT write; host dmi_req_ready_o=0 during INJ_*.
5. Pin high then low within one injection -> HALT then RESUME; a second rise/fall during INJ_RSP causes no extra write. DM returns resp=2 on HALT -> inj_err_o=1 until reset.
6. rst_ni low during INJ_RSP -> all valids/readies 0 next cycle; INIT write reissued after release; halt_active_o=0.
